// File: rtl/if_pkg.sv
// Shared widths, reset PC, state encoding and buffer-entry type for the instruction-fetch stage.
// The instruction-memory load port is compiled in only when IF_LOAD_PORT_EN is defined.
package if_pkg;

  localparam int PC_W    = 32;
  localparam int IMEM_AW = 7;
  localparam int INSN_W  = 32;

  localparam logic [PC_W-1:0] RESET_PC   = 32'h0000_0000;
  localparam logic [PC_W-1:0] PC_STEP    = 32'h0000_0004;
  localparam logic [PC_W-1:0] PC_WORD_MASK = 32'hFFFF_FFFC;

  typedef enum logic {
    LOAD  = 1'b0,
    FETCH = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INSN_W-1:0] insn;
  } fetch_entry_t;

  // Word index into the I_Cache for a byte PC; the upper PC bits wrap naturally.
  function automatic logic [IMEM_AW-1:0] pc_to_index(input logic [PC_W-1:0] pc);
    logic [PC_W-1:0] w_shifted;
    w_shifted = pc >> 2;
    return w_shifted[IMEM_AW-1:0];
  endfunction

endpackage

// File: rtl/if_skid_fifo.sv
// Two-entry in-order buffer of {pc, insn} records that catches fetched words decode cannot take yet.
module if_skid_fifo
  import if_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_data,
  output fetch_entry_t o_head,
  output logic [1:0]   o_count
);

  fetch_entry_t r_mem [0:1];
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_count;

  // Storage, pointers and occupancy; a flush empties the buffer and wins over push/pop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the PC, drives the I_Cache address, absorbs its 1-cycle read latency and
// hands {pc, insn} to decode through a 2-entry skid buffer. Optional load port: IF_LOAD_PORT_EN.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [PC_W-1:0] P_RESET_PC = RESET_PC
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  output logic [IMEM_AW-1:0] o_imem_a,
  output logic               o_imem_wen,
  output logic [INSN_W-1:0]  o_imem_d,
  input  logic [INSN_W-1:0]  i_imem_q,
  input  logic               i_redirect_valid,
  input  logic [PC_W-1:0]    i_redirect_pc,
`ifdef IF_LOAD_PORT_EN
  input  logic               i_load_valid,
  output logic               o_load_ready,
  input  logic [IMEM_AW-1:0] i_load_addr,
  input  logic [INSN_W-1:0]  i_load_data,
  input  logic               i_load_done,
`endif
  output logic               o_inst_valid,
  input  logic               i_inst_ready,
  output logic [PC_W-1:0]    o_inst_pc,
  output logic [INSN_W-1:0]  o_inst_data
);

`ifdef IF_LOAD_PORT_EN
  localparam fetch_state_e C_RESET_STATE = LOAD;
`else
  localparam fetch_state_e C_RESET_STATE = FETCH;
`endif

  fetch_state_e      r_state;
  logic [PC_W-1:0]   r_pc;
  logic              r_inflight;
  logic [PC_W-1:0]   r_inflight_pc;

  logic              w_fetch;
  logic              w_load_wr;
  logic              w_load_done;
  logic              w_redirect;
  logic              w_pop;
  logic              w_issue;
  logic [2:0]        w_occ;
  logic              w_fifo_push;
  logic              w_fifo_pop;
  logic              w_fifo_flush;
  logic [1:0]        w_count;
  fetch_entry_t      w_head;
  fetch_entry_t      w_return;

  assign w_fetch = (r_state == FETCH);

`ifdef IF_LOAD_PORT_EN
  assign w_load_wr    = (r_state == LOAD) && i_load_valid;
  assign w_load_done  = (r_state == LOAD) && i_load_done;
  assign o_load_ready = (r_state == LOAD);
  assign o_imem_a     = w_load_wr ? i_load_addr : pc_to_index(r_pc);
  assign o_imem_wen   = ~w_load_wr;
  assign o_imem_d     = w_load_wr ? i_load_data : {INSN_W{1'b0}};
`else
  assign w_load_wr    = 1'b0;
  assign w_load_done  = 1'b0;
  assign o_imem_a     = pc_to_index(r_pc);
  assign o_imem_wen   = 1'b1;
  assign o_imem_d     = {INSN_W{1'b0}};
`endif

  assign w_return = '{pc: r_inflight_pc, insn: i_imem_q};

  // Handshake, issue decision and buffer control; occupancy counts the word still in the RAM.
  always_comb begin
    w_redirect   = 1'b0;
    w_pop        = 1'b0;
    w_issue      = 1'b0;
    w_occ        = 3'd0;
    w_fifo_push  = 1'b0;
    w_fifo_pop   = 1'b0;
    w_fifo_flush = 1'b0;
    o_inst_valid = 1'b0;
    o_inst_pc    = {PC_W{1'b0}};
    o_inst_data  = {INSN_W{1'b0}};
    if (w_fetch) begin
      w_redirect   = i_redirect_valid;
      o_inst_valid = (w_count != 2'd0) || r_inflight;
      w_pop        = o_inst_valid && i_inst_ready;
      w_occ        = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
      w_issue      = !i_redirect_valid && (w_occ < 3'd2);
      w_fifo_pop   = w_pop && (w_count != 2'd0);
      // The RAM output is overwritten next cycle, so an unconsumed return must be captured now.
      w_fifo_push  = r_inflight && !w_redirect && !(w_pop && (w_count == 2'd0));
      w_fifo_flush = w_redirect;
      if (w_count != 2'd0) begin
        o_inst_pc   = w_head.pc;
        o_inst_data = w_head.insn;
      end else if (r_inflight) begin
        o_inst_pc   = w_return.pc;
        o_inst_data = w_return.insn;
      end else begin
        o_inst_pc   = {PC_W{1'b0}};
        o_inst_data = {INSN_W{1'b0}};
      end
    end else begin
      w_fifo_flush = w_load_done;
    end
  end

  // State, PC and in-flight tracking; a redirect kills the outstanding read and suppresses issue.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= C_RESET_STATE;
      r_pc          <= P_RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= {PC_W{1'b0}};
    end else begin
      case (r_state)
        LOAD: begin
          r_inflight <= 1'b0;
          if (w_load_done) begin
            r_state <= FETCH;
            r_pc    <= P_RESET_PC;
          end else begin
            r_state <= LOAD;
          end
        end
        FETCH: begin
          r_state <= FETCH;
          if (w_redirect) begin
            r_pc       <= i_redirect_pc & PC_WORD_MASK;
            r_inflight <= 1'b0;
          end else if (w_issue) begin
            r_pc          <= r_pc + PC_STEP;
            r_inflight    <= 1'b1;
            r_inflight_pc <= r_pc;
          end else begin
            r_inflight <= 1'b0;
          end
        end
        default: begin
          r_state    <= C_RESET_STATE;
          r_pc       <= P_RESET_PC;
          r_inflight <= 1'b0;
        end
      endcase
    end
  end

  if_skid_fifo u_skid (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_fifo_push),
    .i_pop   (w_fifo_pop),
    .i_flush (w_fifo_flush),
    .i_data  (w_return),
    .o_head  (w_head),
    .o_count (w_count)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit with a behavioural 128x32 synchronous RAM.
module tb_if_fetch_unit;
  import if_pkg::*;

  logic               clk;
  logic               rst_n;
  logic [IMEM_AW-1:0] imem_a;
  logic               imem_wen;
  logic [INSN_W-1:0]  imem_d;
  logic [INSN_W-1:0]  imem_q;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               inst_valid;
  logic               inst_ready;
  logic [PC_W-1:0]    inst_pc;
  logic [INSN_W-1:0]  inst_data;
`ifdef IF_LOAD_PORT_EN
  logic               load_valid;
  logic               load_ready;
  logic [IMEM_AW-1:0] load_addr;
  logic [INSN_W-1:0]  load_data;
  logic               load_done;
`endif

  logic [INSN_W-1:0] mem [0:127];
  int total;
  int bad;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] edata;
    logic        ca;
    logic [6:0]  ea;
  } vec_t;

  vec_t vecs [0:24];

  if_fetch_unit dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .o_imem_a         (imem_a),
    .o_imem_wen       (imem_wen),
    .o_imem_d         (imem_d),
    .i_imem_q         (imem_q),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
`ifdef IF_LOAD_PORT_EN
    .i_load_valid     (load_valid),
    .o_load_ready     (load_ready),
    .i_load_addr      (load_addr),
    .i_load_data      (load_data),
    .i_load_done      (load_done),
`endif
    .o_inst_valid     (inst_valid),
    .i_inst_ready     (inst_ready),
    .o_inst_pc        (inst_pc),
    .o_inst_data      (inst_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!imem_wen) mem[imem_a] <= imem_d;
    imem_q <= mem[imem_a];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rpc,
                              input logic ev, input logic [31:0] epc, input logic [31:0] edata,
                              input logic ca, input logic [6:0] ea);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.ev = ev;
    v.epc = epc; v.edata = edata; v.ca = ca; v.ea = ea;
    return v;
  endfunction

  task automatic enter_fetch();
`ifdef IF_LOAD_PORT_EN
    load_done = 1'b1;
    #1;
    check("load_ready_in_load", {63'd0, load_ready}, 64'd1);
    @(negedge clk);
    load_done = 1'b0;
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {63'd0, inst_valid}, 64'd0);
    check({tag, "_pc"},    {32'd0, inst_pc},    64'd0);
    check({tag, "_data"},  {32'd0, inst_data},  64'd0);
    check({tag, "_wen"},   {63'd0, imem_wen},   64'd1);
    check({tag, "_imem_a"}, {57'd0, imem_a},    64'd0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    for (int i = 0; i < 128; i++) mem[i] = 32'hA000_0000 + i;
    rst_n = 1'b0;
    inst_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
`ifdef IF_LOAD_PORT_EN
    load_valid = 1'b0;
    load_addr = 7'd0;
    load_data = 32'd0;
    load_done = 1'b0;
`endif

    vecs[0]  = mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,         1'b1, 7'd0);
    vecs[1]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   32'hA000_0000, 1'b0, 7'd0);
    vecs[2]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h4,   32'hA000_0001, 1'b0, 7'd0);
    vecs[3]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   32'hA000_0002, 1'b0, 7'd0);
    vecs[4]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'hC,   32'hA000_0003, 1'b0, 7'd0);
    vecs[5]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  32'hA000_0004, 1'b0, 7'd0);
    vecs[6]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  32'hA000_0004, 1'b0, 7'd0);
    vecs[7]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  32'hA000_0004, 1'b0, 7'd0);
    vecs[8]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  32'hA000_0004, 1'b0, 7'd0);
    vecs[9]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  32'hA000_0004, 1'b0, 7'd0);
    vecs[10] = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h10,  32'hA000_0004, 1'b0, 7'd0);
    vecs[11] = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h14,  32'hA000_0005, 1'b0, 7'd0);
    vecs[12] = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h18,  32'hA000_0006, 1'b0, 7'd0);
    vecs[13] = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h1C,  32'hA000_0007, 1'b0, 7'd0);
    vecs[14] = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h20,  32'hA000_0008, 1'b0, 7'd0);
    vecs[15] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h24,  32'hA000_0009, 1'b0, 7'd0);
    vecs[16] = mk(1'b0, 1'b1, 32'h43,  1'b1, 32'h24,  32'hA000_0009, 1'b0, 7'd0);
    vecs[17] = mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,         1'b1, 7'd16);
    vecs[18] = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h40,  32'hA000_0010, 1'b0, 7'd0);
    vecs[19] = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h44,  32'hA000_0011, 1'b0, 7'd0);
    vecs[20] = mk(1'b1, 1'b1, 32'h1FC, 1'b1, 32'h48,  32'hA000_0012, 1'b0, 7'd0);
    vecs[21] = mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,         1'b1, 7'd127);
    vecs[22] = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h1FC, 32'hA000_007F, 1'b1, 7'd0);
    vecs[23] = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h200, 32'hA000_0000, 1'b0, 7'd0);
    vecs[24] = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h204, 32'hA000_0001, 1'b0, 7'd0);

    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    enter_fetch();

    for (int k = 0; k < 25; k++) begin
      inst_ready = vecs[k].rdy;
      redirect_valid = vecs[k].rv;
      redirect_pc = vecs[k].rpc;
      #1;
      check($sformatf("v%0d_valid", k), {63'd0, inst_valid}, {63'd0, vecs[k].ev});
      if (vecs[k].ev) begin
        check($sformatf("v%0d_pc", k),   {32'd0, inst_pc},   {32'd0, vecs[k].epc});
        check($sformatf("v%0d_data", k), {32'd0, inst_data}, {32'd0, vecs[k].edata});
      end
      if (vecs[k].ca) check($sformatf("v%0d_imem_a", k), {57'd0, imem_a}, {57'd0, vecs[k].ea});
      check($sformatf("v%0d_wen", k), {63'd0, imem_wen}, 64'd1);
      @(negedge clk);
    end

    // Fill the buffer, then pull reset mid-cycle: outputs must clear without waiting for a clock.
    redirect_valid = 1'b0;
    inst_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("prefill_valid", {63'd0, inst_valid}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    inst_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    enter_fetch();
    #1;
    check("restart_c0_valid", {63'd0, inst_valid}, 64'd0);
    @(negedge clk);
    #1;
    check("restart_c1_valid", {63'd0, inst_valid}, 64'd1);
    check("restart_c1_pc",    {32'd0, inst_pc},    64'h0);
    check("restart_c1_data",  {32'd0, inst_data},  64'hA000_0000);
    @(negedge clk);
    #1;
    check("restart_c2_pc",    {32'd0, inst_pc},    64'h4);
    check("restart_c2_data",  {32'd0, inst_data},  64'hA000_0001);

`ifdef IF_LOAD_PORT_EN
    // Load three words, with load_done sharing the cycle of the last write.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_addr = 7'(i);
      load_data = 32'hDEAD_BEE0 + i;
      load_done = (i == 2);
      redirect_valid = 1'b1;
      redirect_pc = 32'h40;
      #1;
      check($sformatf("load%0d_wen", i), {63'd0, imem_wen}, 64'd0);
      check($sformatf("load%0d_a", i), {57'd0, imem_a}, {57'd0, 7'(i)});
      check($sformatf("load%0d_d", i), {32'd0, imem_d}, {32'd0, 32'hDEAD_BEE0 + i});
      check($sformatf("load%0d_valid", i), {63'd0, inst_valid}, 64'd0);
      @(negedge clk);
    end
    load_valid = 1'b0;
    load_done = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check("post_load_wen", {63'd0, imem_wen}, 64'd1);
    check("post_load_valid", {63'd0, inst_valid}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("loaded%0d_pc", i),   {32'd0, inst_pc},   {32'd0, 32'(4 * i)});
      check($sformatf("loaded%0d_data", i), {32'd0, inst_data}, {32'd0, 32'hDEAD_BEE0 + i});
      check($sformatf("loaded%0d_wen", i),  {63'd0, imem_wen},  64'd1);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
